// File: rtl/kgp_pipe_pkg.sv
// Shared types and constants for the KGP pipeline boundary registers.
package kgp_pipe_pkg;

    localparam int unsigned KGP_INSTR_W = 32;
    localparam int unsigned KGP_PC_W    = 32;
    localparam logic [31:0] KGP_NOP     = 32'h0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    // Number of buffered beats held in a given state.
    function automatic logic [1:0] occ_of(input pipe_state_e s);
        case (s)
            FULL:    return 2'd1;
            SKID:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/kgp_sat_counter.sv
// Saturating up-counter with synchronous clear; shared by all stage stall stats.
module kgp_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID boundary: 2-entry skid buffer with ready/valid on both sides,
// redirect flush, and a saturating stall counter.
module if_id_skid_reg
    import kgp_pipe_pkg::*;
#(
    parameter int unsigned        INSTR_W   = KGP_INSTR_W,
    parameter int unsigned        PC_W      = KGP_PC_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(KGP_NOP),
    parameter logic [PC_W-1:0]    RESET_PC  = '0,
    parameter int unsigned        STAT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [1:0]         occupancy,
    output logic [STAT_W-1:0]  stall_cnt
);

    pipe_state_e        state;
    pipe_state_e        state_nxt;
    logic               load_main_in;
    logic               load_main_skid;
    logic               load_skid;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;

    // Next state and load strobes. in_ready is (state != SKID) and out_valid is
    // (state != EMPTY), so in_valid/out_ready alone qualify transfers per state.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_valid) begin
                    load_main_in = 1'b1;
                    state_nxt    = FULL;
                end
            end
            FULL: begin
                if (in_valid && out_ready) begin
                    load_main_in = 1'b1;
                end else if (in_valid) begin
                    load_skid = 1'b1;
                    state_nxt = SKID;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            SKID: begin
                if (out_ready) begin
                    load_main_skid = 1'b1;
                    state_nxt      = FULL;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // State, handshake outputs and data registers; flush discards every buffered beat.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state      <= EMPTY;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            occupancy  <= 2'd0;
            out_instr  <= NOP_INSTR;
            out_pc     <= RESET_PC;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != SKID);
            out_valid <= (state_nxt != EMPTY);
            occupancy <= occ_of(state_nxt);
            if (load_main_in) begin
                out_instr <= in_instr;
                out_pc    <= in_pc;
            end else if (load_main_skid) begin
                out_instr <= skid_instr;
                out_pc    <= skid_pc;
            end
            if (load_skid) begin
                skid_instr <= in_instr;
                skid_pc    <= in_pc;
            end
        end
    end

    kgp_sat_counter #(
        .W (STAT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (out_valid && !out_ready),
        .count (stall_cnt)
    );

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
Parametrised IF/ID pipeline boundary register for the KGP RISC core. It replaces the plain latch-every-cycle register with a 2-entry skid buffer using ready/valid handshakes on both sides. It supports back-pressure from decode, flushes on branch/jump redirect, and NOP insertion. A saturating stall counter supports performance debug.

Parameters:
INSTR_W, 32, instruction word width
PC_W, 32, program counter width
NOP_INSTR, 32'h0000_0000, value driven on out_instr after reset/flush (width INSTR_W)
RESET_PC, 32'h0000_0000, value driven on out_pc after reset/flush (width PC_W)
STAT_W, 16, width of stall counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  redirect from EX; kills all buffered beats
in_valid  in  1  fetch presents a beat
in_ready  out  1  buffer accepts a beat this cycle
in_instr  in  INSTR_W  fetched instruction
in_pc  in  PC_W  PC of fetched instruction
out_valid  out  1  decode-side beat valid
out_ready  in  1  decode consumes beat this cycle
out_instr  out  INSTR_W  instruction to decode
out_pc  out  PC_W  PC to decode
occupancy  out  2  buffered beats, 0..2
stall_cnt  out  STAT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Handshakes: upstream transfer = in_valid & in_ready; downstream transfer = out_valid & out_ready. in_valid/out_ready may toggle freely. A beat is never duplicated or reordered.
- in_ready is a registered output, equal to (state != SKID). No combinational path from out_ready to in_ready.
- Storage: main register (drives out_*), plus one skid register.
- FSM states: EMPTY (occ 0), FULL (occ 1, main valid), SKID (occ 2, main+skid valid). out_valid = (state != EMPTY).
- EMPTY: upstream beat -> main<=in, go FULL.
- FULL, in & out transfer -> main<=in, stay FULL.
- FULL, in transfer only -> skid<=in, go SKID.
- FULL, out transfer only -> go EMPTY; main data held, since out_valid qualifies it.
- SKID: in_ready=0, so no input is accepted. On out transfer -> main<=skid, go FULL.
- Latency: 1 cycle in->out when empty. Full throughput (1 beat/cycle) when out_ready is held high.
- Priority: reset > flush > normal operation.
- reset: state=EMPTY, out_valid=0, in_ready=1, out_instr=NOP_INSTR, out_pc=RESET_PC, skid cleared, occupancy=0, stall_cnt=0.
- flush: same register effect as reset, except stall_cnt keeps counting. Any beat presented on the flush cycle is dropped, even if in_valid & in_ready. Any downstream transfer on the flush cycle still counts as consumed by decode; decode ignores it per the EX redirect.
- Mid-operation reset or flush in SKID: both beats discarded; in_ready=1 on the next cycle.
- stall_cnt: +1 each cycle out_valid & !out_ready. Saturates at all-ones; no wrap. Cleared only by reset.
- Data registers update only on a load. X on in_instr/in_pc while in_valid=0 must never reach out_*.

Decomposition:
- Shared package kgp_pipe_pkg holds:
  - state enum {EMPTY, FULL, SKID}, 2 bits;
  - localparam KGP_NOP = 32'h0;
  - localparam KGP_INSTR_W = 32, KGP_PC_W = 32.
- Natural sub-module: kgp_sat_counter (parametrised width, inc, clr, saturating). The same counter will be reused for ID/EX and EX/MEM stall stats.
- Datapath registers and FSM stay in if_id_skid_reg.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1, in_instr=32'hDEAD_BEEF -> out_valid=0, out_instr=0, out_pc=0, in_ready=1, occupancy=0, stall_cnt=0.
- Streaming: out_ready=1, drive PCs 0x00,0x04,0x08 with instrs 0x11,0x22,0x33 on consecutive cycles -> same beats appear on out_* one cycle later, in order, out_valid=1 each cycle, occupancy=1.
- Back-pressure: out_ready=0 while sending PC 0x10 then 0x14 -> occupancy 1 then 2, in_ready=0 after second beat, out_pc holds 0x10. Release out_ready -> out_pc 0x10 then 0x14, no loss, no duplicate.
- Flush in SKID: occupancy=2, assert flush with in_valid=1, in_pc=0x40 -> next cycle out_valid=0, out_instr=NOP_INSTR, out_pc=RESET_PC, in_ready=1. 0x40 never appears on out_pc.
- Stall counter saturation: STAT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds. A flush does not clear it; reset does.
- Random: constrained-random in_valid/out_ready over 10k cycles against a scoreboard FIFO model -> order preserved, zero drops except beats on flush cycles, occupancy never >2.
